// File: rtl/simplebus_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | simplebus_rr_arbiter: round-robin burst arbiter onto one simplebus lane   |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module simplebus_rr_arbiter #(
  parameter int NREQ     = 4,
  parameter int DW       = 8,
  parameter int SRCW     = 2,
  parameter int MAXBURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]    req_last,
  output logic [NREQ-1:0]    gnt,
  output logic               bus_valid,
  output logic [DW-1:0]      bus_data,
  output logic [SRCW-1:0]    bus_src,
  output logic               bus_last,
  input  logic               bus_ready,
  output logic               busy
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_OWN  = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [SRCW-1:0] owner_q, owner_d;
  logic [SRCW-1:0] rr_ptr_q, rr_ptr_d;
  logic [3:0]      beat_cnt_q, beat_cnt_d;
  logic            bus_valid_q, bus_valid_d;
  logic [DW-1:0]   bus_data_q, bus_data_d;
  logic [SRCW-1:0] bus_src_q, bus_src_d;
  logic            bus_last_q, bus_last_d;
  logic            busy_q;

  logic            pick_vld;
  logic [SRCW-1:0] pick_idx;
  logic [SRCW-1:0] next_owner;
  logic            take;
  logic            last_cond;

  // Scan downwards so the requester closest to rr_ptr overwrites the others.
  always_comb begin
    int idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (req[idx]) begin
        pick_vld = 1'b1;
        pick_idx = SRCW'(idx);
      end
    end
  end

  assign next_owner = SRCW'((int'(owner_q) + 1) % NREQ);
  assign take       = (state_q == S_OWN) && req[owner_q] && (!bus_valid_q || bus_ready);
  assign last_cond  = req_last[owner_q] || (beat_cnt_q + 4'd1 == 4'(MAXBURST));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      bus_valid_q <= 1'b0;
      bus_data_q  <= '0;
      bus_src_q   <= '0;
      bus_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      bus_valid_q <= bus_valid_d;
      bus_data_q  <= bus_data_d;
      bus_src_q   <= bus_src_d;
      bus_last_q  <= bus_last_d;
      busy_q      <= (state_d == S_OWN);
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d    = S_OWN;
          owner_d    = pick_idx;
          beat_cnt_d = '0;
        end
      end
      S_OWN: begin
        // A requester that drops mid-burst forfeits its turn without a last beat.
        if (!req[owner_q]) begin
          state_d  = S_IDLE;
          rr_ptr_d = next_owner;
        end else if (take) begin
          beat_cnt_d = beat_cnt_q + 4'd1;
          if (last_cond) begin
            state_d  = S_IDLE;
            rr_ptr_d = next_owner;
          end
        end
      end
    endcase
  end

  always_comb begin
    bus_valid_d = bus_valid_q;
    bus_data_d  = bus_data_q;
    bus_src_d   = bus_src_q;
    bus_last_d  = bus_last_q;
    if (take) begin
      bus_valid_d = 1'b1;
      bus_data_d  = req_data[owner_q*DW +: DW];
      bus_src_d   = owner_q;
      bus_last_d  = last_cond;
    end else if (bus_valid_q && bus_ready) begin
      bus_valid_d = 1'b0;
    end
  end

  always_comb begin
    gnt = '0;
    if (!rst && take) begin
      gnt[owner_q] = 1'b1;
    end
  end

  assign bus_valid = bus_valid_q;
  assign bus_data  = bus_data_q;
  assign bus_src   = bus_src_q;
  assign bus_last  = bus_last_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_simplebus_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_simplebus_rr_arbiter: directed per-cycle vectors for the arbiter        |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module tb_simplebus_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  gnt;
  logic        bus_valid;
  logic [7:0]  bus_data;
  logic [1:0]  bus_src;
  logic        bus_last;
  logic        bus_ready;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  simplebus_rr_arbiter #(.NREQ(4), .DW(8), .SRCW(2), .MAXBURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .req_last  (req_last),
    .gnt       (gnt),
    .bus_valid (bus_valid),
    .bus_data  (bus_data),
    .bus_src   (bus_src),
    .bus_last  (bus_last),
    .bus_ready (bus_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // One record per clock: inputs for the cycle and the outputs visible during it.
  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  last;
    logic        rdy;
    logic [3:0]  gnt;
    logic        v;
    logic [7:0]  d;
    logic [1:0]  s;
    logic        l;
    logic        b;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [31:0] dt,
                              input logic [3:0] ls, input logic rd, input logic [3:0] g,
                              input logic v, input logic [7:0] d, input logic [1:0] s,
                              input logic l, input logic b);
    vec_t x;
    x.rst = r; x.req = rq; x.data = dt; x.last = ls; x.rdy = rd;
    x.gnt = g; x.v = v; x.d = d; x.s = s; x.l = l; x.b = b;
    return x;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
    end
  endtask

  task automatic cyc(input vec_t x, input int row);
    @(negedge clk);
    rst       = x.rst;
    req       = x.req;
    req_data  = x.data;
    req_last  = x.last;
    bus_ready = x.rdy;
    #1;
    chk("gnt", row, 32'(gnt), 32'(x.gnt));
    chk("bus_valid", row, 32'(bus_valid), 32'(x.v));
    chk("busy", row, 32'(busy), 32'(x.b));
    if (x.v) begin
      chk("bus_data", row, 32'(bus_data), 32'(x.d));
      chk("bus_src", row, 32'(bus_src), 32'(x.s));
      chk("bus_last", row, 32'(bus_last), 32'(x.l));
    end
  endtask

  initial begin
    // reset state, then single requester 0x11,0x22,0x33
    tbl.push_back(mk(1, 4'h0, 32'h0,  4'h0, 1, 4'h0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 4'h1, 32'h11, 4'h0, 1, 4'h0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 4'h1, 32'h11, 4'h0, 1, 4'h1, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 4'h1, 32'h22, 4'h0, 1, 4'h1, 1, 8'h11, 0, 0, 1));
    tbl.push_back(mk(0, 4'h1, 32'h33, 4'h1, 1, 4'h1, 1, 8'h22, 0, 0, 1));
    tbl.push_back(mk(0, 4'h0, 32'h0,  4'h0, 1, 4'h0, 1, 8'h33, 0, 1, 0));
    // round robin over all four, one-beat bursts, after a reset to rr_ptr=0
    tbl.push_back(mk(1, 4'hF, 32'h43424140, 4'hF, 1, 4'h0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 4'hF, 32'h43424140, 4'hF, 1, 4'h0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 4'hF, 32'h43424140, 4'hF, 1, 4'h1, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 4'hF, 32'h43424140, 4'hF, 1, 4'h0, 1, 8'h40, 0, 1, 0));
    tbl.push_back(mk(0, 4'hF, 32'h43424140, 4'hF, 1, 4'h2, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 4'hF, 32'h43424140, 4'hF, 1, 4'h0, 1, 8'h41, 1, 1, 0));
    tbl.push_back(mk(0, 4'hF, 32'h43424140, 4'hF, 1, 4'h4, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 4'hF, 32'h43424140, 4'hF, 1, 4'h0, 1, 8'h42, 2, 1, 0));
    tbl.push_back(mk(0, 4'hF, 32'h43424140, 4'hF, 1, 4'h8, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 4'hF, 32'h43424140, 4'hF, 1, 4'h0, 1, 8'h43, 3, 1, 0));
    tbl.push_back(mk(0, 4'hF, 32'h43424140, 4'hF, 1, 4'h1, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 4'h0, 32'h0,        4'h0, 1, 4'h0, 1, 8'h40, 0, 1, 0));
    // requester 2 streams 6 beats: cut at 4, regranted for the last 2
    tbl.push_back(mk(0, 4'h4, 32'h00600000, 4'h0, 1, 4'h0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 4'h4, 32'h00600000, 4'h0, 1, 4'h4, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 4'h4, 32'h00610000, 4'h0, 1, 4'h4, 1, 8'h60, 2, 0, 1));
    tbl.push_back(mk(0, 4'h4, 32'h00620000, 4'h0, 1, 4'h4, 1, 8'h61, 2, 0, 1));
    tbl.push_back(mk(0, 4'h4, 32'h00630000, 4'h0, 1, 4'h4, 1, 8'h62, 2, 0, 1));
    tbl.push_back(mk(0, 4'h4, 32'h00640000, 4'h0, 1, 4'h0, 1, 8'h63, 2, 1, 0));
    tbl.push_back(mk(0, 4'h4, 32'h00640000, 4'h0, 1, 4'h4, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 4'h4, 32'h00650000, 4'h4, 1, 4'h4, 1, 8'h64, 2, 0, 1));
    tbl.push_back(mk(0, 4'h0, 32'h0,        4'h0, 1, 4'h0, 1, 8'h65, 2, 1, 0));
    tbl.push_back(mk(0, 4'h0, 32'h0,        4'h0, 1, 4'h0, 0, 8'h00, 0, 0, 0));

    rst = 1'b1; req = '0; req_data = '0; req_last = '0; bus_ready = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) cyc(tbl[i], i);

    // backpressure: 0xA5 held for three stalled cycles, 0x5A taken when ready returns
    cyc(mk(0, 4'h1, 32'hA5, 4'h0, 1, 4'h0, 0, 8'h00, 0, 0, 0), 100);
    cyc(mk(0, 4'h1, 32'hA5, 4'h0, 1, 4'h1, 0, 8'h00, 0, 0, 1), 101);
    cyc(mk(0, 4'h1, 32'h5A, 4'h0, 0, 4'h0, 1, 8'hA5, 0, 0, 1), 102);
    cyc(mk(0, 4'h1, 32'h5A, 4'h0, 0, 4'h0, 1, 8'hA5, 0, 0, 1), 103);
    cyc(mk(0, 4'h1, 32'h5A, 4'h0, 0, 4'h0, 1, 8'hA5, 0, 0, 1), 104);
    cyc(mk(0, 4'h1, 32'h5A, 4'h1, 1, 4'h1, 1, 8'hA5, 0, 0, 1), 105);
    cyc(mk(0, 4'h0, 32'h0,  4'h0, 1, 4'h0, 1, 8'h5A, 0, 1, 0), 106);
    cyc(mk(0, 4'h0, 32'h0,  4'h0, 1, 4'h0, 0, 8'h00, 0, 0, 0), 107);

    // owner 1 drops after two beats; requester 3 is next
    cyc(mk(0, 4'hA, 32'h81007100, 4'h0, 1, 4'h0, 0, 8'h00, 0, 0, 0), 200);
    cyc(mk(0, 4'hA, 32'h81007100, 4'h0, 1, 4'h2, 0, 8'h00, 0, 0, 1), 201);
    cyc(mk(0, 4'hA, 32'h81007200, 4'h0, 1, 4'h2, 1, 8'h71, 1, 0, 1), 202);
    cyc(mk(0, 4'h8, 32'h81000000, 4'h0, 1, 4'h0, 1, 8'h72, 1, 0, 1), 203);
    cyc(mk(0, 4'h8, 32'h81000000, 4'h0, 1, 4'h0, 0, 8'h00, 0, 0, 0), 204);
    cyc(mk(0, 4'h8, 32'h81000000, 4'h8, 1, 4'h8, 0, 8'h00, 0, 0, 1), 205);
    cyc(mk(0, 4'h0, 32'h0,        4'h0, 1, 4'h0, 1, 8'h81, 3, 1, 0), 206);

    // reset with a beat in flight; lowest requester wins afterwards
    cyc(mk(0, 4'h4, 32'h00900000, 4'h0, 1, 4'h0, 0, 8'h00, 0, 0, 0), 300);
    cyc(mk(0, 4'h4, 32'h00900000, 4'h0, 1, 4'h4, 0, 8'h00, 0, 0, 1), 301);
    cyc(mk(1, 4'h6, 32'h00909100, 4'h0, 1, 4'h0, 1, 8'h90, 2, 0, 1), 302);
    cyc(mk(0, 4'h6, 32'h00909100, 4'h0, 1, 4'h0, 0, 8'h00, 0, 0, 0), 303);
    cyc(mk(0, 4'h6, 32'h00909100, 4'h2, 1, 4'h2, 0, 8'h00, 0, 0, 1), 304);
    cyc(mk(0, 4'h0, 32'h0,        4'h0, 1, 4'h0, 1, 8'h91, 1, 1, 0), 305);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/simplebus_rr_arbiter.md
Name: simplebus_rr_arbiter

Overview:
- Round-robin arbiter that shares a single simplebus transmit channel among NREQ requesters.
- Grants bus ownership for one burst at a time, bounded by MAXBURST beats.
- Forwards each accepted beat through a one-entry registered output stage with a valid/ready handshake.
- Sits between the requesting agents and the simplebus interface instance in the top level.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 8, data width per beat.
- SRCW, 2, width of source-ID field; must satisfy 2**SRCW >= NREQ.
- MAXBURST, 4, maximum beats per grant before forced release (1..15).

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester beat-available flag.
- req_data  input  NREQ*DW  per-requester beat data; requester i occupies bits [i*DW +: DW].
- req_last  input  NREQ  per-requester last-beat-of-burst flag.
- gnt  output  NREQ  one-hot, combinational; beat from requester i is consumed this cycle.
- bus_valid  output  1  registered; output beat present.
- bus_data  output  DW  registered beat data.
- bus_src  output  SRCW  registered index of the requester that supplied the beat.
- bus_last  output  1  registered; beat closes a burst (req_last or MAXBURST cutoff).
- bus_ready  input  1  downstream accepts the beat when bus_valid && bus_ready.
- busy  output  1  registered; high while in OWN.

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - state=IDLE, owner=0, rr_ptr=0, beat_cnt=0.
  - bus_valid=0, bus_data=0, bus_src=0, bus_last=0, busy=0.
  - gnt is 0 during any cycle with rst=1.
- Reset mid-burst discards the output register contents. No beat is delivered after reset.
- States: IDLE, OWN.
- IDLE:
  - gnt=0.
  - If req!=0, select the first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - Next cycle: owner=i, state=OWN, beat_cnt=0, busy=1.
  - Arbitration costs exactly one dead cycle per burst.
- OWN:
  - take = req[owner] && (!bus_valid || bus_ready).
  - gnt[owner] = take; all other gnt bits are 0.
  - On take, the output register loads: bus_data=req_data[owner], bus_src=owner, bus_valid=1.
  - On take, beat_cnt increments, and bus_last = req_last[owner] || (beat_cnt+1 == MAXBURST).
- Burst end:
  - Occurs when take && bus_last-condition is true.
  - Next cycle: state=IDLE, rr_ptr=(owner+1) mod NREQ, busy=0.
- Requester drop:
  - If req[owner]=0 in OWN, the burst is abandoned.
  - Next cycle: state=IDLE, rr_ptr=(owner+1) mod NREQ.
  - No beat is taken and no bus_last is emitted. Downstream must tolerate this; it is a protocol error on the requester side.
- Output register:
  - If bus_valid && bus_ready and no take, bus_valid clears.
  - Take with bus_ready in the same cycle gives back-to-back throughput of 1 beat/cycle.
  - bus_valid && !bus_ready holds bus_data, bus_src and bus_last stable; gnt stays 0.
- The last beat may still sit in the output register after returning to IDLE. A new owner's first take waits for it to drain, via the same take rule.
- The pointer only advances past the owner, so every continuously requesting agent is granted within NREQ bursts (no starvation).
- beat_cnt is 4 bits and saturates to no effect because the burst ends at MAXBURST.
- The arbiter never inspects req_data. req_last is sampled only on take.

Test Plan:
- Single requester:
  - Stimulus: reset; req=0001; req_data[0] sequence 0x11, 0x22, 0x33; req_last on the third beat; bus_ready=1.
  - Response: busy rises 1 cycle after req; gnt=0001 for 3 consecutive cycles; bus_data 0x11, 0x22, 0x33 with bus_src=0; bus_last=1 only on 0x33; busy falls, rr_ptr=1.
- Round-robin:
  - Stimulus: req=1111 held; every burst 1 beat (req_last=1).
  - Response: grant order 0,1,2,3,0; each burst separated by exactly one IDLE cycle; bus_src sequence 0,1,2,3,0.
- MAXBURST cutoff:
  - Stimulus: requester 2 streams 6 beats with req_last=0; req=0100.
  - Response: 4 beats, with bus_last=1 on the 4th; one IDLE cycle; then requester 2 is regranted for the remaining 2 beats.
- Backpressure:
  - Stimulus: bus_ready=0 for 3 cycles after the first beat 0xA5.
  - Response: bus_valid=1, bus_data=0xA5 stable; gnt=0 during the stall; the next beat is taken in the cycle bus_ready returns to 1, with no loss or duplication.
- Requester drop:
  - Stimulus: owner 1 deasserts req after 2 beats, while req[3]=1.
  - Response: state returns to IDLE; the next grant goes to 3; no bus_last is emitted for owner 1.
- Reset mid-burst:
  - Stimulus: rst=1 for 1 cycle while bus_valid=1 and busy=1.
  - Response: the next cycle shows bus_valid=0, busy=0, gnt=0; the first grant after reset goes to the lowest requesting index ≥0.
